// File: rtl/frame_desc_queue.sv
// ---------------------------------------------------------------------------
// frame_desc_queue
//
// Circular descriptor queue controller wrapped around the frame_table RAM.
// The block owns both RAM ports. The frame assembler pushes descriptors into
// it and the scheduler pops them in FIFO order. The RAM read is registered,
// with one cycle of latency. A 2-entry output buffer (head + skid) hides that
// latency so the scheduler sees a plain valid/ready interface.
//
// Ports
//   clk            single clock, shared with frame_table
//   rst_n          asynchronous active-low reset
//   clr            synchronous flush; empties the queue (RAM contents kept)
//   push_valid     upstream descriptor valid
//   push_ready     queue can accept a descriptor (registers only)
//   push_desc      descriptor to store
//   pop_valid      pop_desc holds the oldest descriptor
//   pop_ready      downstream consumes the descriptor
//   pop_desc       head descriptor
//   level          descriptors held: RAM + read in flight + output buffer
//   ram_data       frame_table write data
//   ram_write_addr frame_table write address
//   ram_we         frame_table write enable
//   ram_read_addr  frame_table read address (always rptr)
//   ram_q          frame_table registered read data (old data on collision)
//
// Output buffer states (out_cnt)
//   state     | meaning
//   OUT_EMPTY | no descriptor buffered, pop_valid low
//   OUT_ONE   | head holds the oldest descriptor
//   OUT_TWO   | head plus skid both loaded
// ---------------------------------------------------------------------------
module frame_desc_queue #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_desc,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_desc,
  output logic [ADDR_WIDTH+1:0] level,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [1:0] OUT_EMPTY = 2'd0;
  localparam logic [1:0] OUT_ONE   = 2'd1;
  localparam logic [1:0] OUT_TWO   = 2'd2;

  // DEPTH expressed in pointer width (wrap bit set, address bits zero)
  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   ram_used;
  logic                  rd_inflight;
  logic [1:0]            out_cnt;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;

  logic                  push_fire;
  logic                  pop_fire;
  logic                  issue;
  logic                  capture;
  logic [2:0]            slots_busy;
  logic [2:0]            slots_cap;

  // Modulo subtraction across the wrap bit gives 0..DEPTH
  assign ram_used   = wptr - rptr;
  assign push_ready = (ram_used < DEPTH_W);

  // A push during clr is dropped even though push_ready reads 1
  assign push_fire      = push_valid & push_ready & ~clr;
  assign ram_we         = push_fire;
  assign ram_data       = push_desc;
  assign ram_write_addr = wptr[ADDR_WIDTH-1:0];
  assign ram_read_addr  = rptr[ADDR_WIDTH-1:0];

  assign pop_valid = (out_cnt != OUT_EMPTY);
  assign pop_desc  = head_q;
  assign pop_fire  = pop_valid & pop_ready & ~clr;
  assign capture   = rd_inflight;

  // The buffer has two slots. A read is issued only if its data will have a
  // slot when it returns. A pop in the same cycle frees a slot in time, so it
  // counts toward the free slots. Without that credit, steady push/pop would
  // bubble every third cycle. The bound still means a capture can never land
  // while both slots are full.
  assign slots_busy = {1'b0, out_cnt} + {2'b00, rd_inflight};
  assign slots_cap  = 3'd2 + {2'b00, pop_fire};
  assign issue      = (ram_used != '0) & ~clr & (slots_busy < slots_cap);

  assign level = {1'b0, ram_used}
               + {{(ADDR_WIDTH+1){1'b0}}, rd_inflight}
               + {{ADDR_WIDTH{1'b0}}, out_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      rd_inflight <= 1'b0;
    end else if (clr) begin
      wptr        <= '0;
      rptr        <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (push_fire) wptr <= wptr + 1'b1;
      if (issue)     rptr <= rptr + 1'b1;
      rd_inflight <= issue;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= OUT_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (clr) begin
      out_cnt <= OUT_EMPTY;
    end else begin
      case (out_cnt)
        OUT_EMPTY: begin
          if (capture) begin
            head_q  <= ram_q;
            out_cnt <= OUT_ONE;
          end
        end
        OUT_ONE: begin
          if (capture && pop_fire) begin
            head_q <= ram_q;
          end else if (capture) begin
            skid_q  <= ram_q;
            out_cnt <= OUT_TWO;
          end else if (pop_fire) begin
            out_cnt <= OUT_EMPTY;
          end
        end
        OUT_TWO: begin
          if (pop_fire) begin
            head_q  <= skid_q;
            out_cnt <= OUT_ONE;
          end
        end
        default: out_cnt <= OUT_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_desc_queue.sv
module tb_frame_desc_queue;

  localparam int DW = 40;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_desc = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [DW-1:0] pop_desc;
  logic [AW+1:0] level;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_write_addr;
  logic          ram_we;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_q;

  always #5 clk = ~clk;

  frame_desc_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .push_valid(push_valid), .push_ready(push_ready), .push_desc(push_desc),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_desc(pop_desc),
    .level(level), .ram_data(ram_data), .ram_write_addr(ram_write_addr),
    .ram_we(ram_we), .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  // frame_table stand-in: registered read, old data on same-address collision
  logic [DW-1:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    ram_q = '0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  int checks = 0;
  int failures = 0;

  // Reference model: ordered contents of the queue, nothing more
  logic [DW-1:0] model[$];
  logic [DW-1:0] got[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_desc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check against model, update model
  task automatic cyc(input logic pv, input logic [DW-1:0] d, input logic pr,
                     input logic c, output logic acc);
    logic popped;
    @(negedge clk);
    push_valid = pv; push_desc = d; pop_ready = pr; clr = c;
    #1;
    chk("level_vs_model", 64'(level), 64'(model.size()));
    if (pop_valid) begin
      if (model.size() == 0) chk("pop_valid_when_empty", 64'(pop_valid), 64'd0);
      else chk("pop_order", 64'(pop_desc), 64'(model[0]));
    end
    if (prev_stall) begin
      chk("stall_valid_held", 64'(pop_valid), 64'd1);
      chk("stall_desc_stable", 64'(pop_desc), 64'(prev_desc));
    end
    if (model.size() < 16) chk("push_ready_not_full", 64'(push_ready), 64'd1);
    if (model.size() == 18) chk("push_ready_full", 64'(push_ready), 64'd0);
    acc = pv & push_ready & ~c;
    popped = pop_valid & pr & ~c;
    if (c) model.delete();
    else begin
      if (popped) begin
        got.push_back(pop_desc);
        if (model.size() > 0) void'(model.pop_front());
      end
      if (acc) model.push_back(d);
    end
    prev_stall = pop_valid & ~pr & ~c;
    prev_desc = pop_desc;
  endtask

  task automatic drain(input string name, input int maxc);
    logic acc;
    for (int i = 0; i < maxc && model.size() != 0; i++) cyc(1'b0, '0, 1'b1, 1'b0, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chk(name, 64'(level), 64'd0);
  endtask

  typedef struct {
    logic          pv;
    logic [DW-1:0] d;
    logic          pr;
    logic          e_pop_valid;
    logic [DW-1:0] e_desc;
    logic [AW+1:0] e_level;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic acc;
    logic [DW-1:0] nxt;
    int pushed;

    vecs[0]  = '{1'b1, 40'hA1, 1'b1, 1'b0, 40'h0,  6'd0};
    vecs[1]  = '{1'b0, 40'h0,  1'b1, 1'b0, 40'h0,  6'd1};
    vecs[2]  = '{1'b0, 40'h0,  1'b1, 1'b0, 40'h0,  6'd1};
    vecs[3]  = '{1'b0, 40'h0,  1'b1, 1'b1, 40'hA1, 6'd1};
    vecs[4]  = '{1'b0, 40'h0,  1'b0, 1'b0, 40'h0,  6'd0};
    vecs[5]  = '{1'b1, 40'hB1, 1'b0, 1'b0, 40'h0,  6'd0};
    vecs[6]  = '{1'b1, 40'hB2, 1'b0, 1'b0, 40'h0,  6'd1};
    vecs[7]  = '{1'b0, 40'h0,  1'b0, 1'b0, 40'h0,  6'd2};
    vecs[8]  = '{1'b0, 40'h0,  1'b0, 1'b1, 40'hB1, 6'd2};
    vecs[9]  = '{1'b0, 40'h0,  1'b1, 1'b1, 40'hB1, 6'd2};
    vecs[10] = '{1'b0, 40'h0,  1'b1, 1'b1, 40'hB2, 6'd1};
    vecs[11] = '{1'b0, 40'h0,  1'b0, 1'b0, 40'h0,  6'd0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_pop_desc", 64'(pop_desc), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Directed latency table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      push_valid = vecs[i].pv; push_desc = vecs[i].d; pop_ready = vecs[i].pr;
      #1;
      chk($sformatf("vec%0d_pop_valid", i), 64'(pop_valid), 64'(vecs[i].e_pop_valid));
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].e_level));
      if (vecs[i].e_pop_valid)
        chk($sformatf("vec%0d_pop_desc", i), 64'(pop_desc), 64'(vecs[i].e_desc));
    end

    // 2. Fill to 18 with no pops, then pop all in order
    got.delete();
    nxt = 40'd1;
    for (int i = 0; i < 60 && nxt <= 40'd18; i++) begin
      cyc(1'b1, nxt, 1'b0, 1'b0, acc);
      if (acc) nxt++;
    end
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t2_full_level", 64'(level), 64'd18);
    chk("t2_full_push_ready", 64'(push_ready), 64'd0);
    cyc(1'b1, 40'h99, 1'b0, 1'b0, acc);
    chk("t2_push_rejected", 64'(acc), 64'd0);
    drain("t2_drain", 100);
    chk("t2_pop_count", 64'(got.size()), 64'd18);
    for (int i = 0; i < got.size(); i++) chk("t2_pop_seq", 64'(got[i]), 64'(i + 1));

    // 3. Full queue, push and pop every cycle
    nxt = 40'h1000;
    for (int i = 0; i < 60 && level != 18; i++) begin
      cyc(1'b1, nxt, 1'b0, 1'b0, acc);
      if (acc) nxt++;
    end
    chk("t3_full", 64'(level), 64'd18);
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, nxt, 1'b1, 1'b0, acc);
      if (acc) nxt++;
    end
    drain("t3_drain", 100);

    // 4. Streaming 1/cycle across pointer wrap
    got.delete();
    nxt = 40'h2000;
    for (int i = 0; i < 80; i++) begin
      cyc(1'b1, nxt, 1'b1, 1'b0, acc);
      chk("t4_push_accepted", 64'(acc), 64'd1);
      if (i >= 3) chk("t4_no_bubble", 64'(pop_valid), 64'd1);
      if (acc) nxt++;
    end
    drain("t4_drain", 20);
    chk("t4_pop_count", 64'(got.size()), 64'd80);
    for (int i = 0; i < got.size(); i++) chk("t4_seq", 64'(got[i]), 64'(40'h2000 + i));

    // 5. Random traffic with backpressure
    pushed = 0;
    for (int i = 0; i < 10000 && pushed < 1000; i++) begin
      cyc(($urandom % 4) != 0, {8'($urandom), 32'($urandom)}, 1'($urandom % 2), 1'b0, acc);
      if (acc) pushed++;
    end
    chk("t5_pushed_1000", 64'(pushed), 64'd1000);
    drain("t5_drain", 200);

    // 6a. clr with 7 held; push and pop in the clr cycle are ignored
    for (int i = 0; i < 7; i++) cyc(1'b1, 40'h700 + 40'(i), 1'b0, 1'b0, acc);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t6_level7", 64'(level), 64'd7);
    cyc(1'b1, 40'h77, 1'b1, 1'b1, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t6_clr_level", 64'(level), 64'd0);
    chk("t6_clr_pop_valid", 64'(pop_valid), 64'd0);
    repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, acc);
    got.delete();
    cyc(1'b1, 40'h55, 1'b0, 1'b0, acc);
    drain("t6_clr_drain", 20);
    chk("t6_clr_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("t6_clr_desc", 64'(got[0]), 64'h55);

    // 6b. Async reset mid-burst
    for (int i = 0; i < 10; i++) cyc(1'b1, 40'h900 + 40'(i), (i > 5), 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("t6_rst_push_ready", 64'(push_ready), 64'd1);
    model.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    push_valid = 1'b0; pop_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    chk("t6_post_rst_pop_valid", 64'(pop_valid), 64'd0);
    got.delete();
    cyc(1'b1, 40'h55, 1'b0, 1'b0, acc);
    drain("t6_rst_drain", 20);
    chk("t6_rst_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("t6_rst_desc", 64'(got[0]), 64'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
